// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared constants, FSM state encoding and helpers for the
//                UART transmitter and its FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Frame FSM state encoding (2-bit)
    localparam logic [1:0] UART_IDLE  = 2'd0;
    localparam logic [1:0] UART_START = 2'd1;
    localparam logic [1:0] UART_DATA  = 2'd2;
    localparam logic [1:0] UART_STOP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = UART_IDLE,
        ST_START = UART_START,
        ST_DATA  = UART_DATA,
        ST_STOP  = UART_STOP
    } uart_state_t;

    // 8N1 framing: start + 8 data + stop
    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;

    // Clock cycles per bit; truncating division
    function automatic int uart_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Small synchronous circular-buffer FIFO with occupancy count.
//                Read data is the combinational head entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,      // synchronous, active-low
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);
    localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);
    localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(DEPTH);

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
            $error("uart_tx_fifo: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Overflow/underflow protection lives here so callers can be simple
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop  && !o_empty;

    assign o_full  = (r_count == c_CNT_MAX);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    // Storage array; contents need no reset because the count guards reads
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; push+pop keeps count
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : Buffered 8N1 UART transmitter, LSB first, fixed baud rate.
//                Bytes enter through a valid/ready port into a FIFO and are
//                shifted out back-to-back with no idle gap between frames.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 12_000_000,
    parameter int BAUD       = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,      // synchronous, active-low
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    output logic       busy,
    output logic       txd
);

    localparam int DIV  = uart_div(CLK_FREQ, BAUD);
    localparam int c_BW = (DIV < 2) ? 1 : $clog2(DIV);
    localparam int c_CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [c_BW-1:0] c_BAUD_LAST = c_BW'(DIV - 1);
    localparam logic [c_BW-1:0] c_BAUD_ONE  = c_BW'(1);
    localparam logic [2:0]      c_LAST_BIT  = 3'(UART_DATA_BITS - 1);

    generate
        if (DIV < 2) begin : g_div_check
            $error("uart_tx: CLK_FREQ/BAUD must be at least 2");
        end
    endgenerate

    uart_state_t      r_state;
    logic [c_BW-1:0]  r_baud;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_txd;

    logic             w_bit_end;
    logic             w_pop;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [c_CW-1:0]  w_fifo_count;
    logic [7:0]       w_head;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (wr_valid),
        .i_data  (wr_data),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign w_bit_end = (r_baud == c_BAUD_LAST);

    // Pop when idle, or at the very end of a stop bit so frames chain seamlessly
    assign w_pop = !w_fifo_empty &&
                   ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_bit_end));

    // Ready looks only at the registered count, never at this cycle's pop
    assign wr_ready = !w_fifo_full;
    assign busy     = (r_state != ST_IDLE) || (w_fifo_count != '0);
    assign txd      = r_txd;

    // Frame FSM: baud counter, bit index, shift register and registered txd
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_txd     <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_txd  <= 1'b1;
                    r_baud <= '0;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_txd   <= 1'b0;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_txd     <= r_shift[0];
                        r_state   <= ST_DATA;
                    end else begin
                        r_baud <= r_baud + c_BAUD_ONE;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (r_bit_idx == c_LAST_BIT) begin
                            r_txd   <= 1'b1;
                            r_state <= ST_STOP;
                        end else begin
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_txd     <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + c_BAUD_ONE;
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_txd   <= 1'b0;
                            r_state <= ST_START;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + c_BAUD_ONE;
                    end
                end
                default: begin
                    r_txd   <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
